// File: rtl/sched_pkg.sv
// sched_pkg: shared FSM state encoding and default sizing for the process scheduler
package sched_pkg;
    typedef enum logic [1:0] {OFF, RUN, REQ, IDLE} state_t;
    localparam int QUANTUM_W   = 8;
    localparam int N_PROC_DEF  = 8;
    localparam int QUANTUM_DEF = 32;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin pick of the next runnable process after cur_proc
// ready_mask in  runnable processes
// cur_proc   in  current owner, checked last
// pick       out first ready index scanning cur_proc+1 upward with wrap
// any_ready  out some process is runnable
module rr_pick #(
    parameter int N_PROC = 8,
    parameter int PW     = $clog2(N_PROC)
) (
    input  logic [N_PROC-1:0] ready_mask,
    input  logic [PW-1:0]     cur_proc,
    output logic [PW-1:0]     pick,
    output logic              any_ready
);
    // scan from farthest to nearest so the nearest ready slot wins
    always_comb begin
        pick = cur_proc;
        for (int k = N_PROC; k >= 1; k--) begin
            int idx;
            idx = (int'(cur_proc) + k) % N_PROC;
            if (ready_mask[idx[PW-1:0]]) pick = idx[PW-1:0];
        end
    end
    assign any_ready = |ready_mask;
endmodule

// File: rtl/process_scheduler.sv
// process_scheduler: round-robin time-slice scheduler requesting context swaps
// clk/reset    clock, async active-high reset
// enable       scheduling active
// tick, yield  retired instruction / voluntary give-up of current process
// ready_mask   runnable processes
// swap_ack     context swap done
// swap_req, next_proc, cur_proc, quantum_left, idle  registered status
module process_scheduler
    import sched_pkg::*;
#(
    parameter int N_PROC  = N_PROC_DEF,
    parameter int QUANTUM = QUANTUM_DEF,
    parameter int PW      = $clog2(N_PROC)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 tick,
    input  logic                 yield,
    input  logic [N_PROC-1:0]    ready_mask,
    input  logic                 swap_ack,
    output logic                 swap_req,
    output logic [PW-1:0]        next_proc,
    output logic [PW-1:0]        cur_proc,
    output logic [QUANTUM_W-1:0] quantum_left,
    output logic                 idle
);
    localparam logic [QUANTUM_W-1:0] Q = QUANTUM_W'(QUANTUM);
    state_t state, state_n;
    logic [PW-1:0] pick, next_n, cur_n;
    logic [QUANTUM_W-1:0] ql_n;
    logic any_ready, hit, moved;

    rr_pick #(.N_PROC(N_PROC), .PW(PW)) u_pick (
        .ready_mask(ready_mask),
        .cur_proc  (cur_proc),
        .pick      (pick),
        .any_ready (any_ready)
    );

    // a yield makes any same-cycle tick irrelevant, so both together form one event
    assign hit   = yield | (tick & (quantum_left == QUANTUM_W'(1)));
    assign moved = pick != cur_proc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= OFF;
            swap_req     <= 1'b0;
            next_proc    <= '0;
            cur_proc     <= '0;
            quantum_left <= '0;
            idle         <= 1'b0;
        end else begin
            state        <= state_n;
            swap_req     <= state_n == REQ;
            next_proc    <= next_n;
            cur_proc     <= cur_n;
            quantum_left <= ql_n;
            idle         <= state_n == IDLE;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            OFF:     state_n = !enable ? OFF : any_ready ? RUN : IDLE;
            RUN:     state_n = !enable ? OFF : !hit ? RUN : !any_ready ? IDLE : moved ? REQ : RUN;
            REQ:     state_n = !swap_ack ? REQ : enable ? RUN : OFF;
            IDLE:    state_n = !enable ? OFF : !any_ready ? IDLE : moved ? REQ : RUN;
            default: state_n = OFF;
        endcase
    end

    // next_proc latches only on entry to REQ, so ready_mask changes cannot disturb it
    always_comb begin
        next_n = (state != REQ && state_n == REQ) ? pick : next_proc;
        cur_n  = (state == REQ && state_n != REQ) ? next_proc : cur_proc;
        ql_n   = ((state == REQ && state_n != REQ) || (state != RUN && state_n == RUN) ||
                  (state == RUN && state_n == RUN && hit)) ? Q :
                 (state == RUN && state_n == RUN && tick) ? quantum_left - QUANTUM_W'(1) :
                 quantum_left;
    end
endmodule

// File: doc/process_scheduler.md
PROCESS_SCHEDULER -- requirements
Module: process_scheduler

Interface
REQ-001 Parameter N_PROC, default 8, SHALL set the number of process slots; legal range 2..16.
REQ-002 Parameter QUANTUM, default 32, SHALL set the ticks per time slice; legal range 1..255.
REQ-003 Parameter PW, default $clog2(N_PROC), SHALL set the width of process indices.
REQ-004 Port list: clk  in  1  system clock (the divided core clock); one clock; reset is asynchronous and active-high.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  scheduling active; low means the OS runs alone.
REQ-007 tick  in  1  one retired instruction of the current process.
REQ-008 yield  in  1  one-cycle pulse: the current process halted or yielded voluntarily.
REQ-009 ready_mask  in  N_PROC  bit i is 1 when process i is runnable.
REQ-010 swap_ack  in  1  the process keeper has completed the context swap.
REQ-011 swap_req  out  1  a context switch to next_proc is requested.
REQ-012 next_proc  out  PW  target process of the pending switch.
REQ-013 cur_proc  out  PW  process currently owning the core.
REQ-014 quantum_left  out  8  ticks remaining in the current slice.
REQ-015 idle  out  1  no runnable process exists.

Function
REQ-016 The FSM SHALL have exactly four states: OFF, RUN, REQ and IDLE; all outputs SHALL be registered.
REQ-017 OFF SHALL go to RUN when enable=1 and ready_mask is nonzero, and to IDLE when enable=1 and ready_mask is zero.
REQ-018 On entry to RUN, quantum_left SHALL load QUANTUM.
REQ-019 In RUN, each cycle with tick=1 SHALL decrement quantum_left by 1.
REQ-020 The slice SHALL expire on the cycle where tick=1 and quantum_left=1.
REQ-021 Pick rule: the candidate SHALL be the first set bit of ready_mask scanning cur_proc+1 upward, wrapping modulo N_PROC, with cur_proc itself checked last.
REQ-022 On expiry or yield, if the candidate differs from cur_proc, the FSM SHALL go to REQ with swap_req=1 and next_proc=candidate on the following cycle; latency is 1 cycle.
REQ-023 On expiry or yield, if the candidate equals cur_proc, the FSM SHALL stay in RUN, reload QUANTUM and raise no request.
REQ-024 On expiry or yield, if ready_mask is zero, the FSM SHALL go to IDLE with idle=1.
REQ-025 A simultaneous yield and expiry SHALL produce exactly one request.
REQ-026 A tick in the same cycle as a yield SHALL be ignored.
REQ-027 In REQ, swap_req and next_proc SHALL be held stable until swap_ack=1.
REQ-028 On swap_ack in REQ: cur_proc SHALL take next_proc, swap_req SHALL drop next cycle, quantum_left SHALL reload QUANTUM, and the FSM SHALL go to RUN.
REQ-029 In REQ, tick and yield SHALL be ignored, and changes to ready_mask SHALL NOT alter next_proc.
REQ-030 swap_ack SHALL be ignored outside REQ.
REQ-031 IDLE SHALL leave when ready_mask becomes nonzero: go to REQ targeting the pick from cur_proc, or go to RUN with idle=0 if the pick equals cur_proc.
REQ-032 With enable=0, RUN and IDLE SHALL go to OFF next cycle.
REQ-033 With enable=0, REQ SHALL finish the handshake first and then go to OFF.
REQ-034 In OFF, quantum_left SHALL hold its value and swap_req SHALL be 0.

Reset
REQ-035 While reset=1, asynchronously: state=OFF, swap_req=0, next_proc=0, cur_proc=0, quantum_left=0, idle=0.
REQ-036 A reset during REQ SHALL abandon the request with no further swap_req assertion.
REQ-037 Reset release SHALL be sampled synchronously: the first transition out of OFF occurs no earlier than the first clk edge after release.

Structure
REQ-038 A shared package sched_pkg SHALL hold the state enum (OFF, RUN, REQ, IDLE), QUANTUM_W=8, and the default N_PROC and QUANTUM values.
REQ-039 The round-robin picker SHALL be one combinational sub-module, rr_pick, with inputs ready_mask and cur_proc and outputs pick and any_ready.
REQ-040 The remaining logic (FSM and quantum counter) SHALL reside in process_scheduler.

Verification
REQ-041 Reset, then enable=1, ready_mask=8'b0000_0011, tick every cycle, QUANTUM=4 -> swap_req=1 with next_proc=1 on the cycle after the 4th tick; ack -> cur_proc=1, quantum_left=4.
REQ-042 cur_proc=1, ready_mask=8'b1000_0001, yield pulse -> next_proc=7; then ready_mask changes to 8'b0000_0001 while in REQ -> next_proc stays 7 until ack.
REQ-043 ready_mask=8'b0000_0100, cur_proc=2, 4 ticks -> no swap_req and quantum_left reloads to 4; yield and expiry in the same cycle -> no swap_req.
REQ-044 ready_mask=0 at expiry -> idle=1; ready_mask=8'b0010_0000 -> swap_req with next_proc=5 and idle=0 after ack.
REQ-045 Reset asserted mid-REQ -> swap_req=0 immediately, with no clk edge required; enable dropped in REQ -> the handshake completes, then state OFF with swap_req=0.
